paralelo_serial_tx: RTL and testbench

//  Transmit side of the 2-bit serial link; sits directly upstream of the serial-to-parallel receiver.

---
 rtl/paralelo_serial_tx.sv | 108 ++++++++++
 tb/tb_paralelo_serial_tx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paralelo_serial_tx.sv
// Transmit side of the 2-bit serial link: trains with comma words after reset, then
// serializes buffered 8-bit words MSB pair first, filling idle slots with the comma word.
module paralelo_serial_tx #(
  parameter int unsigned TRAIN_WORDS = 4,
  parameter logic [7:0]  COMMA       = 8'hBC
) (
  input  logic       clk16,
  input  logic       reset16,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] serial,
  output logic       link_up,
  output logic       word_start,
  output logic       data_word,
  output logic       err_comma
);

  localparam int unsigned WORD_W  = 8;
  localparam int unsigned PHASE_W = 2;
  localparam int unsigned CNT_W   = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;

  typedef enum logic {TRAIN, RUN} state_t;

  state_t              state, state_n;
  logic [WORD_W-1:0]   shreg, shreg_n;
  logic [PHASE_W-1:0]  phase, phase_n;
  logic [WORD_W-1:0]   word_buf, word_buf_n;
  logic                buf_full, buf_full_n;
  logic [CNT_W-1:0]    train_cnt, train_cnt_n;
  logic                data_word_n;
  logic                err_comma_n;
  logic                accept;

  assign serial = shreg[7:6];

  // Next-state: shift within a word, pick the next word at the boundary, capture accepts.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    phase_n     = phase;
    word_buf_n  = word_buf;
    buf_full_n  = buf_full;
    train_cnt_n = train_cnt;
    data_word_n = data_word;
    accept      = in_valid & ~buf_full;

    if (phase == PHASE_W'(3)) begin
      phase_n = '0;
      if (state == TRAIN && train_cnt != CNT_W'(TRAIN_WORDS - 1)) begin
        shreg_n     = COMMA;
        train_cnt_n = train_cnt + CNT_W'(1);
        data_word_n = 1'b0;
      end else begin
        // Last training word rolls straight into RUN, so the first RUN word may be data.
        state_n = RUN;
        if (buf_full) begin
          shreg_n     = word_buf;
          buf_full_n  = 1'b0;
          data_word_n = 1'b1;
        end else begin
          shreg_n     = COMMA;
          data_word_n = 1'b0;
        end
      end
    end else begin
      shreg_n = {shreg[5:0], 2'b00};
      phase_n = phase + PHASE_W'(1);
    end

    if (accept) begin
      word_buf_n = in_data;
      buf_full_n = 1'b1;
    end

    err_comma_n = accept && (in_data == COMMA);
  end

  // State and output registers.
  always_ff @(posedge clk16) begin
    if (reset16) begin
      state      <= TRAIN;
      shreg      <= COMMA;
      phase      <= '0;
      word_buf   <= '0;
      buf_full   <= 1'b0;
      train_cnt  <= '0;
      data_word  <= 1'b0;
      err_comma  <= 1'b0;
      in_ready   <= 1'b1;
      link_up    <= 1'b0;
      word_start <= 1'b1;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      phase      <= phase_n;
      word_buf   <= word_buf_n;
      buf_full   <= buf_full_n;
      train_cnt  <= train_cnt_n;
      data_word  <= data_word_n;
      err_comma  <= err_comma_n;
      in_ready   <= ~buf_full_n;
      link_up    <= (state_n == RUN);
      word_start <= (phase_n == '0);
    end
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx: training, data framing, back-to-back words,
// comma error pulse and reset in the middle of a data word.
module tb_paralelo_serial_tx;

  logic       clk16;
  logic       reset16;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] serial;
  logic       link_up;
  logic       word_start;
  logic       data_word;
  logic       err_comma;

  int total;
  int bad;

  paralelo_serial_tx #(.TRAIN_WORDS(4), .COMMA(8'hBC)) dut (
    .clk16      (clk16),
    .reset16    (reset16),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .serial     (serial),
    .link_up    (link_up),
    .word_start (word_start),
    .data_word  (data_word),
    .err_comma  (err_comma)
  );

  initial clk16 = 1'b0;
  always #5 clk16 = ~clk16;

  task automatic tick();
    @(posedge clk16);
    #1;
  endtask

  // Leaves the bench at cycle 0 (first cycle after reset release).
  task automatic do_reset();
    reset16  = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    reset16 = 1'b0;
  endtask

  // Samples four consecutive symbols; ends at the first cycle of the following word.
  task automatic get_word(output logic [7:0] w, output logic [3:0] ws,
                          output logic [3:0] dw, output logic [3:0] lu);
    w = '0; ws = '0; dw = '0; lu = '0;
    for (int i = 0; i < 4; i++) begin
      w  = {w[5:0], serial};
      ws = {ws[2:0], word_start};
      dw = {dw[2:0], data_word};
      lu = {lu[2:0], link_up};
      tick();
    end
  endtask

  // Waits (bounded) for the first symbol of a data word.
  task automatic wait_data_word(input string name);
    int n;
    n = 0;
    while (!(word_start && data_word) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL %s: timeout waiting for data word", name);
    end
  endtask

  // Holds a word on in_data until it is accepted (bounded).
  task automatic send(input logic [7:0] d, input string name);
    logic acc;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 40) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL %s: word %h never accepted", name, d);
    end
  endtask

  task automatic test_reset();
    reset16  = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    total++;
    if ({serial, link_up, word_start, data_word, err_comma, in_ready} !== 7'b10_0_1_0_0_1) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 1001001",
               {serial, link_up, word_start, data_word, err_comma, in_ready});
    end
    reset16 = 1'b0;
  endtask

  task automatic test_train();
    logic [7:0] w;
    logic [3:0] ws, dw, lu;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      get_word(w, ws, dw, lu);
      total++;
      if ({w, ws, dw, lu} !== {8'hBC, 4'b1000, 4'b0000, 4'b0000}) begin
        bad++;
        $display("FAIL train_word%0d: got w=%h ws=%b dw=%b lu=%b want w=bc ws=1000 dw=0000 lu=0000",
                 k, w, ws, dw, lu);
      end
    end
    total++;
    if (link_up !== 1'b1) begin
      bad++;
      $display("FAIL train_link_up16: got %b want 1", link_up);
    end
    get_word(w, ws, dw, lu);
    total++;
    if ({w, ws, dw, lu} !== {8'hBC, 4'b1000, 4'b0000, 4'b1111}) begin
      bad++;
      $display("FAIL train_idle: got w=%h ws=%b dw=%b lu=%b want w=bc ws=1000 dw=0000 lu=1111",
               w, ws, dw, lu);
    end
  endtask

  task automatic test_data_in_train();
    logic [7:0] w;
    logic [3:0] ws, dw, lu;
    logic       rdy_seen;
    do_reset();
    tick(); tick();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h77;
    rdy_seen = 1'b0;
    for (int c = 3; c < 16; c++) begin
      rdy_seen |= in_ready;
      // This extra offer must be ignored while the buffer is full.
      in_valid = (c == 5);
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (rdy_seen !== 1'b0) begin
      bad++;
      $display("FAIL t2_ready_low: got in_ready high during cycles 3-15 want low");
    end
    total++;
    if ({link_up, in_ready} !== 2'b11) begin
      bad++;
      $display("FAIL t2_cycle16: got link_up/in_ready=%b want 11", {link_up, in_ready});
    end
    get_word(w, ws, dw, lu);
    total++;
    if ({w, ws, dw} !== {8'h5A, 4'b1000, 4'b1111}) begin
      bad++;
      $display("FAIL t2_data: got w=%h ws=%b dw=%b want w=5a ws=1000 dw=1111", w, ws, dw);
    end
    get_word(w, ws, dw, lu);
    total++;
    if ({w, dw} !== {8'hBC, 4'b0000}) begin
      bad++;
      $display("FAIL t2_no_ghost: got w=%h dw=%b want w=bc dw=0000", w, dw);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_w [3];
    logic [7:0] w;
    logic [3:0] ws, dw, lu;
    exp_w[0] = 8'h00; exp_w[1] = 8'hFF; exp_w[2] = 8'h3C;
    fork
      begin
        for (int i = 0; i < 3; i++) send(exp_w[i], "t3_send");
      end
      begin
        wait_data_word("t3_start");
        for (int i = 0; i < 3; i++) begin
          get_word(w, ws, dw, lu);
          total++;
          if ({w, ws, dw} !== {exp_w[i], 4'b1000, 4'b1111}) begin
            bad++;
            $display("FAIL t3_word%0d: got w=%h ws=%b dw=%b want w=%h ws=1000 dw=1111",
                     i, w, ws, dw, exp_w[i]);
          end
        end
      end
    join
  endtask

  task automatic test_single_then_idle();
    logic [7:0] w;
    logic [3:0] ws, dw, lu;
    send(8'hA5, "t4_send");
    wait_data_word("t4_start");
    get_word(w, ws, dw, lu);
    total++;
    if ({w, dw} !== {8'hA5, 4'b1111}) begin
      bad++;
      $display("FAIL t4_data: got w=%h dw=%b want w=a5 dw=1111", w, dw);
    end
    get_word(w, ws, dw, lu);
    total++;
    if ({w, ws, dw} !== {8'hBC, 4'b1000, 4'b0000}) begin
      bad++;
      $display("FAIL t4_idle: got w=%h ws=%b dw=%b want w=bc ws=1000 dw=0000", w, ws, dw);
    end
  endtask

  task automatic test_err_comma();
    logic [7:0] w;
    logic [3:0] ws, dw, lu;
    total++;
    if ({in_ready, err_comma} !== 2'b10) begin
      bad++;
      $display("FAIL t5_pre: got in_ready/err_comma=%b want 10", {in_ready, err_comma});
    end
    in_valid = 1'b1;
    in_data  = 8'hBC;
    tick();
    in_valid = 1'b0;
    total++;
    if (err_comma !== 1'b1) begin
      bad++;
      $display("FAIL t5_pulse: got err_comma=%b want 1", err_comma);
    end
    tick();
    total++;
    if (err_comma !== 1'b0) begin
      bad++;
      $display("FAIL t5_pulse_end: got err_comma=%b want 0", err_comma);
    end
    wait_data_word("t5_start");
    get_word(w, ws, dw, lu);
    total++;
    if ({w, dw} !== {8'hBC, 4'b1111}) begin
      bad++;
      $display("FAIL t5_word: got w=%h dw=%b want w=bc dw=1111", w, dw);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    logic [3:0] ws, dw, lu;
    send(8'hC3, "t6_send0");
    send(8'h11, "t6_send1");
    // Now in phase 1 of C3 with 8'h11 buffered.
    total++;
    if ({serial, data_word, in_ready} !== 4'b00_1_0) begin
      bad++;
      $display("FAIL t6_phase1: got serial/dw/rdy=%b want 0010", {serial, data_word, in_ready});
    end
    tick();
    total++;
    if ({serial, word_start} !== 3'b00_0) begin
      bad++;
      $display("FAIL t6_phase2: got serial/ws=%b want 000", {serial, word_start});
    end
    reset16 = 1'b1;
    tick();
    reset16 = 1'b0;
    total++;
    if ({serial, link_up, in_ready, data_word} !== 5'b10_0_1_0) begin
      bad++;
      $display("FAIL t6_after_reset: got %b want 10010", {serial, link_up, in_ready, data_word});
    end
    for (int k = 0; k < 4; k++) begin
      get_word(w, ws, dw, lu);
      total++;
      if ({w, ws, dw, lu} !== {8'hBC, 4'b1000, 4'b0000, 4'b0000}) begin
        bad++;
        $display("FAIL t6_train%0d: got w=%h ws=%b dw=%b lu=%b want w=bc ws=1000 dw=0000 lu=0000",
                 k, w, ws, dw, lu);
      end
    end
    for (int k = 0; k < 2; k++) begin
      get_word(w, ws, dw, lu);
      total++;
      if ({w, dw, lu} !== {8'hBC, 4'b0000, 4'b1111}) begin
        bad++;
        $display("FAIL t6_post%0d: got w=%h dw=%b lu=%b want w=bc dw=0000 lu=1111",
                 k, w, dw, lu);
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset16  = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_train();
    test_data_in_train();
    test_back_to_back();
    test_single_then_idle();
    test_err_comma();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
